alu_arbiter: RTL and testbench

- Shares the single-cycle combinational ALU between two requesters: requester 0 is the core execute stage, requester 1 is the accelerator/debug port.
- Arbitrates with 2-way round-robin and latches the winning operands.
- Drives the ALU from stable registers, captures the result, and returns it on a per-requester valid/ready response channel.
- Sits between the requesters and the ALU; the ALU itself is unchanged.

---
 rtl/alu_arb_pkg.sv | 39 +++
 rtl/rr_arb2.sv | 32 +++
 rtl/alu_arbiter.sv | 126 ++++++++++++
 tb/tb_alu_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_arb_pkg : ALU function codes, arbiter states and SEL legality check
// Revision    : 1.0
// ---------------------------------------------------------------------------
package alu_arb_pkg;

  typedef enum logic [3:0] {
    SEL_ADD  = 4'b0000,
    SEL_SLL  = 4'b0001,
    SEL_SLT  = 4'b0010,
    SEL_SLTU = 4'b0011,
    SEL_XOR  = 4'b0100,
    SEL_SRL  = 4'b0101,
    SEL_OR   = 4'b0110,
    SEL_AND  = 4'b0111,
    SEL_SUB  = 4'b1000,
    SEL_PASS = 4'b1001,
    SEL_SRA  = 4'b1101
  } alu_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic [31:0] ALU_ILLEGAL_RESULT = 32'hDEADBEEF;

  function automatic logic is_legal_sel(input logic [3:0] sel);
    case (sel)
      SEL_ADD, SEL_SLL, SEL_SLT, SEL_SLTU, SEL_XOR, SEL_SRL,
      SEL_OR, SEL_AND, SEL_SUB, SEL_PASS, SEL_SRA: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arb2  : two-way round-robin arbiter with a one-hot grant
// Revision : 1.0
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic r_ptr;

  // On advance the pointer moves away from the requester just granted, so a
  // lone requester being served never starves the other one afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ptr <= 1'b0;
    else if (advance) r_ptr <= ~grant_id;
  end

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = r_ptr ? 2'b10 : 2'b01;
  end

  assign grant_id = grant[1];

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_arbiter : shares one combinational ALU between two requesters
// Revision    : 1.0
// ---------------------------------------------------------------------------
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [SEL_W-1:0] req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic [SEL_W-1:0] req1_sel,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_illegal,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_illegal,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  arb_state_t       r_state, w_next;
  logic [WIDTH-1:0] r_op1, r_op2, r_result;
  logic [SEL_W-1:0] r_sel;
  logic             r_id, r_illegal;
  logic [1:0]       w_grant;
  logic             w_grant_id, w_accept, w_rsp_ack;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({req1_valid, req0_valid}),
    .advance  (w_accept),
    .grant    (w_grant),
    .grant_id (w_grant_id)
  );

  assign w_accept  = (r_state == IDLE) && (w_grant != 2'b00);
  assign w_rsp_ack = r_id ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant != 2'b00) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (w_rsp_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // READY is masked by rst_n so it stays low while reset is held with VALID up.
  always_comb begin
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    rsp0_illegal = 1'b0;
    rsp1_illegal = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready = rst_n & w_grant[0];
        req1_ready = rst_n & w_grant[1];
      end
      RESP: begin
        rsp0_valid   = ~r_id;
        rsp1_valid   = r_id;
        rsp0_illegal = ~r_id & r_illegal;
        rsp1_illegal = r_id & r_illegal;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op1     <= '0;
      r_op2     <= '0;
      r_sel     <= '0;
      r_id      <= 1'b0;
      r_result  <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op1 <= w_grant_id ? req1_op1 : req0_op1;
        r_op2 <= w_grant_id ? req1_op2 : req0_op2;
        r_sel <= w_grant_id ? req1_sel : req0_sel;
        r_id  <= w_grant_id;
      end
      if (r_state == EXEC) begin
        r_result  <= alu_result;
        r_illegal <= ~is_legal_sel(4'(r_sel));
      end
    end
  end

  assign alu_op1     = r_op1;
  assign alu_op2     = r_op2;
  assign alu_sel     = r_sel;
  assign rsp0_result = r_result;
  assign rsp1_result = r_result;
  assign busy        = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_arbiter : directed scoreboard bench for alu_arbiter
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [3:0]  req0_sel, req1_sel;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_illegal, rsp1_illegal;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [3:0]  alu_sel;
  logic        busy;

  typedef struct {
    bit          id;
    logic [31:0] res;
    bit          ill;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] s);
    case (s)
      4'h0:    return a + b;
      4'h1:    return a << b[4:0];
      4'h2:    return {31'b0, $signed(a) < $signed(b)};
      4'h3:    return {31'b0, a < b};
      4'h4:    return a ^ b;
      4'h5:    return a >> b[4:0];
      4'h6:    return a | b;
      4'h7:    return a & b;
      4'h8:    return a - b;
      4'h9:    return a;
      4'hD:    return $signed(a) >>> b[4:0];
      default: return ALU_ILLEGAL_RESULT;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [3:0] s);
    return (s <= 4'h9) || (s == 4'hD);
  endfunction

  // Stand-in for the unchanged external ALU.
  assign alu_result = ref_alu(alu_op1, alu_op2, alu_sel);

  alu_arbiter #(.WIDTH(32), .SEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_illegal(rsp0_illegal),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_illegal(rsp1_illegal),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
    .alu_result(alu_result), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] s);
    exp_t e;
    e.id  = id;
    e.res = ref_alu(a, b, s);
    e.ill = !ref_legal(s);
    q.push_back(e);
    if (id == 1'b0) begin
      req0_op1 = a; req0_op2 = b; req0_sel = s; req0_valid = 1'b1;
    end else begin
      req1_op1 = a; req1_op2 = b; req1_sel = s; req1_valid = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    q.delete();
  endtask

  // Waits for READY of requester id, lets the accept edge pass, drops VALID.
  task automatic wait_accept(input bit id, input string tag);
    bit got = 1'b0;
    #1;
    for (int i = 0; i < 20 && !got; i++) begin
      if ((id == 1'b0) ? req0_ready : req1_ready) got = 1'b1;
      else step();
    end
    chk(tag, {31'b0, got}, 32'd1);
    step();
    if (id == 1'b0) req0_valid = 1'b0;
    else            req1_valid = 1'b0;
  endtask

  // Waits for a response and compares it with the scoreboard head.
  task automatic wait_rsp(input string tag);
    bit   seen = 1'b0;
    exp_t e;
    #1;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (rsp0_valid || rsp1_valid) seen = 1'b1;
      else step();
    end
    chk({tag, " seen"}, {31'b0, seen}, 32'd1);
    chk({tag, " sb"}, {31'b0, (q.size() > 0)}, 32'd1);
    if (seen && q.size() > 0) begin
      e = q.pop_front();
      chk({tag, " id"}, {31'b0, rsp1_valid}, {31'b0, e.id});
      chk({tag, " other_valid"}, {31'b0, e.id ? rsp0_valid : rsp1_valid}, 32'd0);
      chk({tag, " result"}, e.id ? rsp1_result : rsp0_result, e.res);
      chk({tag, " illegal"}, {31'b0, e.id ? rsp1_illegal : rsp0_illegal}, {31'b0, e.ill});
    end
  endtask

  logic [31:0] t6_a [6];
  logic [31:0] t6_b [6];
  logic [3:0]  t6_s [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n0, n1;
    logic [31:0] held;
    bit          gid;

    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_op1 = '0; req0_op2 = '0; req0_sel = '0;
    req1_op1 = '0; req1_op2 = '0; req1_sel = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (2) step();
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst ready", {30'b0, req1_ready, req0_ready}, 32'd0);
    chk("rst rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst illegal", {30'b0, rsp1_illegal, rsp0_illegal}, 32'd0);
    chk("rst alu_op1", alu_op1, 32'd0);
    chk("rst alu_sel", {28'b0, alu_sel}, 32'd0);
    chk("rst result", rsp0_result, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;

    // T1: single add with latency/BUSY timing
    step();
    issue(1'b0, 32'd5, 32'd7, SEL_ADD);
    #1;
    chk("t1 ready0", {31'b0, req0_ready}, 32'd1);
    chk("t1 ready1", {31'b0, req1_ready}, 32'd0);
    chk("t1 busy_idle", {31'b0, busy}, 32'd0);
    step();
    req0_valid = 1'b0;
    #1;
    chk("t1 busy_exec", {31'b0, busy}, 32'd1);
    chk("t1 no_early_rsp", {31'b0, rsp0_valid}, 32'd0);
    chk("t1 alu_op1", alu_op1, 32'd5);
    step();
    chk("t1 busy_resp", {31'b0, busy}, 32'd1);
    wait_rsp("t1 rsp");
    step();
    chk("t1 busy_done", {31'b0, busy}, 32'd0);
    chk("t1 rsp_drop", {31'b0, rsp0_valid}, 32'd0);

    // T2: both valid after reset, requester 0 first
    do_reset();
    issue(1'b0, 32'd10, 32'd3, SEL_SUB);
    issue(1'b1, 32'h8000_0000, 32'd4, SEL_SRA);
    #1;
    chk("t2 ready1_blocked", {31'b0, req1_ready}, 32'd0);
    wait_accept(1'b0, "t2 acc0");
    wait_rsp("t2 rsp0");
    step();
    wait_accept(1'b1, "t2 acc1");
    wait_rsp("t2 rsp1");
    step();

    // T3: response back-pressure while the other requester waits
    do_reset();
    rsp1_ready = 1'b0;
    issue(1'b1, 32'h0000_F0F0, 32'h0000_0FF0, SEL_XOR);
    wait_accept(1'b1, "t3 acc1");
    issue(1'b0, 32'h0F0, 32'h00F, SEL_OR);
    held = 32'h0000_F0F0 ^ 32'h0000_0FF0;
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      chk("t3 hold_valid", {31'b0, rsp1_valid}, 32'd1);
      chk("t3 hold_result", rsp1_result, held);
      chk("t3 ready0_low", {31'b0, req0_ready}, 32'd0);
    end
    rsp1_ready = 1'b1;
    wait_rsp("t3 rsp1");
    step();
    #1;
    chk("t3 ready0_after", {31'b0, req0_ready}, 32'd1);
    wait_accept(1'b0, "t3 acc0");
    wait_rsp("t3 rsp0");
    step();

    // T4: illegal SEL, then a legal op clears ILLEGAL
    do_reset();
    issue(1'b1, 32'd1, 32'd2, 4'b1010);
    wait_accept(1'b1, "t4 acc_ill");
    wait_rsp("t4 rsp_ill");
    step();
    issue(1'b1, 32'd6, 32'd3, SEL_AND);
    wait_accept(1'b1, "t4 acc_ok");
    wait_rsp("t4 rsp_ok");
    step();

    // T5: reset during EXEC drops the op and restores pointer 0
    do_reset();
    issue(1'b0, 32'd100, 32'd200, SEL_ADD);
    wait_accept(1'b0, "t5 acc");
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("t5 busy_exec", {31'b0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5 rst busy", {31'b0, busy}, 32'd0);
    chk("t5 rst ready", {30'b0, req1_ready, req0_ready}, 32'd0);
    chk("t5 rst rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("t5 rst alu_op1", alu_op1, 32'd0);
    chk("t5 rst alu_op2", alu_op2, 32'd0);
    chk("t5 rst result", rsp0_result, 32'd0);
    q.delete();
    step();
    rst_n = 1'b1;
    issue(1'b0, 32'd9, 32'd4, SEL_SUB);
    issue(1'b1, 32'hFFFF_FFFF, 32'd1, SEL_SLT);
    #1;
    chk("t5 ready0_wins", {31'b0, req0_ready}, 32'd1);
    chk("t5 ready1_low", {31'b0, req1_ready}, 32'd0);
    wait_accept(1'b0, "t5 acc0");
    wait_rsp("t5 rsp0");
    step();
    wait_accept(1'b1, "t5 acc1");
    wait_rsp("t5 rsp1");
    step();

    // T6: both valid continuously, grants must alternate 0,1,0,1,0,1
    do_reset();
    t6_a = '{32'd1, 32'h80, 32'h10, 32'h1234_5678, 32'hFFFF_0000, 32'd2};
    t6_b = '{32'd2, 32'd3, 32'd2, 32'd0, 32'h00FF_00FF, 32'hFFFF_FFFE};
    t6_s = '{SEL_ADD, SEL_SRL, SEL_SLL, SEL_PASS, SEL_OR, SEL_SLTU};
    n0 = 0; n1 = 0;
    issue(1'b0, t6_a[0], t6_b[0], t6_s[0]);
    issue(1'b1, t6_a[1], t6_b[1], t6_s[1]);
    for (int k = 0; k < 6; k++) begin
      bit g = 1'b0;
      #1;
      for (int i = 0; i < 20 && !g; i++) begin
        if (req0_ready || req1_ready) g = 1'b1;
        else step();
      end
      chk("t6 grant_seen", {31'b0, g}, 32'd1);
      chk("t6 grant_id", {31'b0, req1_ready}, k % 2);
      chk("t6 onehot", {31'b0, req0_ready & req1_ready}, 32'd0);
      gid = req1_ready;
      step();
      if (gid == 1'b0) begin
        n0++;
        if (n0 < 3) issue(1'b0, t6_a[2*n0], t6_b[2*n0], t6_s[2*n0]);
        else        req0_valid = 1'b0;
      end else begin
        n1++;
        if (n1 < 3) issue(1'b1, t6_a[2*n1+1], t6_b[2*n1+1], t6_s[2*n1+1]);
        else        req1_valid = 1'b0;
      end
      wait_rsp("t6 rsp");
      step();
    end
    chk("t6 sb_empty", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
